// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between a multicycle core (master) and its
//   memory responder (slave).
//
//   mem_read, mem_write   request strobes, held by the master until mem_resp
//   mem_address           byte address
//   mem_wdata             write data
//   mem_byte_enable       per-byte write mask (bit i -> wdata[8i+7:8i])
//   mem_rdata             read data, meaningful only while mem_resp is high
//   mem_resp              single-cycle completion pulse
//   proto_err             sticky protocol-error flag
//   rd_count, wr_count    completed read/write counters
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        proto_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp, proto_err, rd_count, wr_count
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp, proto_err, rd_count, wr_count
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Word-addressed memory that answers mem_read/mem_write requests with a
//   one-cycle mem_resp pulse LATENCY cycles after acceptance. Writes honour
//   a per-byte enable mask. Tracks protocol errors and completed traffic.
//
//   clk   system clock
//   rst   synchronous active-high reset (control state, outputs, counters;
//         array contents are kept)
//   bus   slave side of mem_responder_if
//
//   Parameters:
//     ADDR_BITS  word-address bits; array depth 2**ADDR_BITS
//     LATENCY    acceptance-to-response delay in cycles, 1..15
module mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state;
    logic [3:0]             lat_cnt;
    logic                   lat_write;
    logic [ADDR_BITS-1:0]   lat_idx;
    logic [31:0]            lat_wdata;
    logic [3:0]             lat_be;

    logic [31:0]            mem_array [2**ADDR_BITS];

    logic                   resp_q;
    logic [31:0]            rdata_q;
    logic                   err_q;
    logic [31:0]            rd_cnt_q;
    logic [31:0]            wr_cnt_q;

    logic [ADDR_BITS-1:0]   req_idx;
    logic                   req_one;
    logic                   req_both;
    logic                   req_held;
    logic                   unused_addr;

    // Byte offset and bits above the array index are ignored (aliasing).
    assign req_idx     = bus.mem_address[ADDR_BITS+1:2];
    assign unused_addr = ^bus.mem_address;

    assign req_one  = bus.mem_read ^ bus.mem_write;
    assign req_both = bus.mem_read & bus.mem_write;
    // A drop or a direction flip both show up as the latched direction's
    // strobe going low.
    assign req_held = lat_write ? bus.mem_write : bus.mem_read;

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            lat_write <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    if (req_both) begin
                        err_q <= 1'b1;
                    end else if (req_one) begin
                        lat_write <= bus.mem_write;
                        lat_cnt   <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            // No WAIT phase: the response is formed from the
                            // live request, the latched copy is not ready yet.
                            state   <= RESP;
                            resp_q  <= 1'b1;
                            rdata_q <= bus.mem_write ? 32'h0 : mem_array[req_idx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (!req_held) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else if (lat_cnt == 4'd1) begin
                        state   <= RESP;
                        resp_q  <= 1'b1;
                        rdata_q <= lat_write ? 32'h0 : mem_array[lat_idx];
                    end
                end

                RESP: begin
                    // Request inputs are ignored here; the master is still
                    // holding its strobe in this cycle.
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    state   <= IDLE;
                    if (lat_write) wr_cnt_q <= wr_cnt_q + 32'd1;
                    else           rd_cnt_q <= rd_cnt_q + 32'd1;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Request capture; later changes on the bus are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_one) begin
            lat_idx   <= req_idx;
            lat_wdata <= bus.mem_wdata;
            lat_be    <= bus.mem_byte_enable;
        end
    end

    // Array write commits at the edge ending RESP; a reset in that cycle
    // discards it.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && lat_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_be[b]) mem_array[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.proto_err = err_q;
    assign bus.rd_count  = rd_cnt_q;
    assign bus.wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed and randomized bench for mem_responder. One instance runs with
//   LATENCY=3 for the functional, error and reset scenarios; a second with
//   LATENCY=1 covers back-to-back throughput.
module tb_mem_responder;

    localparam int AB    = 10;
    localparam int LAT   = 3;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0;
    logic rst;
    logic rst1;

    always #5 clk = ~clk;

    mem_responder_if m3();
    mem_responder_if m1();

    mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (m3.slave)
    );

    mem_responder #(.ADDR_BITS(AB), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (m1.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain word array plus expected counters/flag.
    logic [31:0] model_mem [DEPTH];
    int          written_q [$];
    int          exp_rd  = 0;
    int          exp_wr  = 0;
    logic        exp_err = 1'b0;

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_rd_count"}, m3.rd_count, 32'(exp_rd));
        chk({tag, "_wr_count"}, m3.wr_count, 32'(exp_wr));
        chk({tag, "_proto_err"}, {31'b0, m3.proto_err}, {31'b0, exp_err});
    endtask

    // One full transaction on the LATENCY=3 instance. lat is the cycle
    // number (1 = first cycle after acceptance) in which mem_resp was seen,
    // or -1 on timeout. Bus fields are scrambled right after acceptance.
    task automatic xact3(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        m3.mem_read        = !wr;
        m3.mem_write       = wr;
        m3.mem_address     = addr;
        m3.mem_wdata       = wdata;
        m3.mem_byte_enable = be;
        lat   = -1;
        rdata = 32'h0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                m3.mem_address     = $urandom;
                m3.mem_wdata       = $urandom;
                m3.mem_byte_enable = 4'($urandom);
            end
            if (m3.mem_resp) begin
                lat   = n + 1;
                rdata = m3.mem_rdata;
                break;
            end
        end
        @(negedge clk);
        m3.mem_read  = 1'b0;
        m3.mem_write = 1'b0;
    endtask

    task automatic wr3(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
        logic [31:0] rd;
        logic [31:0] m;
        int          lat;
        int          w;
        xact3(1'b1, addr, data, be, rd, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        w = word_of(addr);
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        model_mem[w] = (model_mem[w] & ~m) | (data & m);
        written_q.push_back(w);
        exp_wr++;
        @(posedge clk);
        #1;
        chk_status(tag);
    endtask

    task automatic rd3(input string tag, input logic [31:0] addr, output logic [31:0] rdata);
        int lat;
        xact3(1'b0, addr, $urandom, 4'($urandom), rdata, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_rdata"}, rdata, model_mem[word_of(addr)]);
        exp_rd++;
        @(posedge clk);
        #1;
        chk_status(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          seen;
        int          lat;

        rst  = 1'b1;
        rst1 = 1'b1;
        m3.mem_read = 1'b0; m3.mem_write = 1'b0; m3.mem_address = '0;
        m3.mem_wdata = '0;  m3.mem_byte_enable = '0;
        m1.mem_read = 1'b0; m1.mem_write = 1'b0; m1.mem_address = '0;
        m1.mem_wdata = '0;  m1.mem_byte_enable = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resp", {31'b0, m3.mem_resp}, 32'h0);
        chk("reset_rdata", m3.mem_rdata, 32'h0);
        chk_status("reset");
        chk("reset1_resp", {31'b0, m1.mem_resp}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        rst1 = 1'b0;

        // Full-word write then read back.
        wr3("w_deadbeef", 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        rd3("r_deadbeef", 32'h0000_0010, rd);
        chk("r_deadbeef_const", rd, 32'hDEAD_BEEF);

        // Partial write merges lanes 0 and 2.
        wr3("w_pre20", 32'h0000_0020, 32'h1122_3344, 4'b1111);
        wr3("w_part20", 32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        rd3("r_part20", 32'h0000_0020, rd);
        chk("r_part20_const", rd, 32'h11BB_33DD);

        // Aliasing: 0x1004 and 0x0006 hit the same word with ADDR_BITS=10.
        wr3("w_alias", 32'h0000_1004, 32'hCAFE_F00D, 4'b1111);
        rd3("r_alias", 32'h0000_0006, rd);
        chk("r_alias_const", rd, 32'hCAFE_F00D);

        // Zero mask completes without touching the array.
        wr3("w_nomask", 32'h0000_0010, 32'h0BAD_0BAD, 4'b0000);
        rd3("r_nomask", 32'h0000_0010, rd);
        chk("r_nomask_const", rd, 32'hDEAD_BEEF);

        // Both strobes high for 5 cycles: never accepted.
        @(negedge clk);
        m3.mem_read = 1'b1; m3.mem_write = 1'b1; m3.mem_address = 32'h10;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (m3.mem_resp) seen = 1'b1;
        end
        @(negedge clk);
        m3.mem_read = 1'b0; m3.mem_write = 1'b0;
        exp_err = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("both_no_resp", {31'b0, seen}, 32'h0);
        chk_status("both");

        // Read dropped one cycle after acceptance.
        @(negedge clk);
        m3.mem_read = 1'b1; m3.mem_address = 32'h20;
        @(negedge clk);
        m3.mem_read = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (m3.mem_resp) seen = 1'b1;
        end
        chk("drop_no_resp", {31'b0, seen}, 32'h0);
        chk_status("drop");

        // Reset during the WAIT phase of a write.
        wr3("w_pre40", 32'h0000_0040, 32'h0000_0000, 4'b1111);
        @(negedge clk);
        m3.mem_write = 1'b1; m3.mem_address = 32'h40;
        m3.mem_wdata = 32'h1234_5678; m3.mem_byte_enable = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        @(posedge clk);
        #1;
        if (m3.mem_resp) seen = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m3.mem_write = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (m3.mem_resp) seen = 1'b1;
        end
        chk("rstmid_no_resp", {31'b0, seen}, 32'h0);
        chk_status("rstmid");
        rd3("r_rstmid", 32'h0000_0040, rd);
        chk("r_rstmid_const", rd, 32'h0000_0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
                addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | ($urandom & 32'hFFFF_F003);
                wr3("rnd_wr", addr, $urandom, 4'($urandom));
            end else begin
                addr = (32'(written_q[$urandom_range(0, written_q.size() - 1)]) << 2)
                       | ($urandom & 32'hFFFF_F003);
                rd3("rnd_rd", addr, rd);
            end
        end

        // LATENCY=1 instance: preload one word, then 4 back-to-back reads.
        @(negedge clk);
        m1.mem_write = 1'b1; m1.mem_address = 32'h80;
        m1.mem_wdata = 32'h5A5A_A5A5; m1.mem_byte_enable = 4'b1111;
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (m1.mem_resp) begin
                lat = n + 1;
                break;
            end
        end
        chk("l1_write_latency", 32'(lat), 32'd1);
        @(negedge clk);
        m1.mem_write = 1'b0;
        @(negedge clk);
        m1.mem_read = 1'b1; m1.mem_address = 32'h80;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            chk("l1_resp_pattern", {31'b0, m1.mem_resp}, 32'(c % 2));
            if (m1.mem_resp) chk("l1_rdata", m1.mem_rdata, 32'h5A5A_A5A5);
            else             chk("l1_rdata_idle", m1.mem_rdata, 32'h0);
        end
        chk("l1_rd_count", m1.rd_count, 32'd4);
        chk("l1_wr_count", m1.wr_count, 32'd1);
        @(negedge clk);
        m1.mem_read = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I datapath/control pair. Answers its mem_read/mem_write requests with a one-cycle mem_resp pulse after a programmable latency.
- Backed by an internal word-addressed array with byte-enable writes.
- Used as the memory model in core-level simulation and as the on-chip memory in synthesis tests.
- Exposes protocol-error and traffic counters for verification.

Parameters:
- ADDR_BITS, 10, number of word-address bits; array depth is 2**ADDR_BITS words.
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mem_read  input  1  read request; held high by the initiator until mem_resp
- mem_write  input  1  write request; held high by the initiator until mem_resp
- mem_address  input  32  byte address; bits [1:0] ignored, bits [ADDR_BITS+1:2] index the array, upper bits ignored (aliasing)
- mem_wdata  input  32  write data
- mem_byte_enable  input  4  write lane mask; bit i enables byte i = wdata[8i+7:8i]
- mem_rdata  output  32  read data, valid only while mem_resp=1 for a read
- mem_resp  output  1  single-cycle completion pulse
- proto_err  output  1  sticky protocol-error flag
- rd_count  output  32  completed reads since reset
- wr_count  output  32  completed writes since reset

Behaviour:
- Reset values: mem_resp=0, mem_rdata=0, proto_err=0, rd_count=0, wr_count=0, FSM=IDLE. Array contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Exactly one of mem_read/mem_write high at a rising edge = request accepted.
  - Latch address index, wdata, byte_enable and direction into internal registers.
  - Load latency counter with LATENCY-1.
  - Go to WAIT, or directly to RESP if LATENCY=1.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
- Timing: request accepted at edge t gives mem_resp=1 during cycle t+LATENCY, for exactly one cycle.
- RESP:
  - mem_resp=1.
  - Read: mem_rdata = array[latched index].
  - Write: at the edge ending RESP, bytes with byte_enable=1 are written; other bytes are unchanged. byte_enable=0000 completes normally with no array change.
  - Counters: rd_count or wr_count increments at that same edge and wraps at 2**32.
  - Next state is always IDLE.
- One idle cycle: the initiator still asserts its request in the RESP cycle. The responder ignores request inputs during RESP, and the earliest next acceptance is the edge after RESP. Back-to-back requests therefore complete every LATENCY+1 cycles.
- Captured values: address, wdata and byte_enable changes after acceptance are ignored.
- mem_rdata outside RESP-read cycles is driven 0.
- Error cases (each sets proto_err to 1 and holds it until rst):
  - mem_read and mem_write both high in IDLE: no acceptance, stay IDLE, no response.
  - Request dropped in WAIT (latched direction's input low): abort to IDLE, no write, no counter increment, no resp.
  - Direction flips during WAIT: treated as a drop.
- rst mid-operation: FSM returns to IDLE next edge, pending write discarded, no resp, counters and proto_err cleared.
- Read-after-write to the same word: the read accepted after a write's RESP returns the merged new data.

Test Plan:
- Write 0xDEADBEEF to addr 0x0000_0010, mask 1111, LATENCY=3. mem_resp high exactly at 3rd cycle after acceptance. Read 0x10 returns 0xDEADBEEF. wr_count=1, rd_count=1.
- Partial write: preload 0x11223344 at 0x20, then write 0xAABBCCDD mask 0101. Read 0x20 returns 0x11BB33DD.
- Aliasing/alignment with ADDR_BITS=10: write 0xCAFEF00D to 0x0000_1004, then read 0x0000_0006. Returns 0xCAFEF00D.
- Protocol errors:
  - mem_read=mem_write=1 for 5 cycles: no mem_resp, proto_err=1.
  - Drop mem_read one cycle after acceptance: no mem_resp ever, rd_count unchanged.
- Reset mid-write: accept write 0x12345678 to 0x40 (old 0x0), assert rst in WAIT. No resp. Read 0x40 returns 0x00000000. Counters=0, proto_err=0.
- Throughput, LATENCY=1: 4 back-to-back reads held until resp. mem_resp pulses every 2 cycles, rd_count=4 after 8 cycles.
